// File: rtl/game_control_mp.sv
// Multi-player game-control FSM: login, setup, RNG capture, player turns,
// verification, game-over and logout for NUM_PLAYERS players.
// Every output is registered; each output follows its cause by one clock.
module game_control_mp #(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned ROTATE      = 1,
    parameter int unsigned MAX_ROUNDS  = 4,
    parameter int unsigned PW          = 3,
    parameter int unsigned RW          = 4
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   Log_In,
    input  logic                   Log_Pls,
    input  logic [NUM_PLAYERS-1:0] P_Pls,
    input  logic                   RNG_Pls,
    input  logic                   Time_Out,
    output logic                   Log_Out,
    output logic                   Pwd_Res,
    output logic [NUM_PLAYERS-1:0] P_Load,
    output logic                   RNG_Load,
    output logic                   Timer_En,
    output logic                   Time_Reconfig,
    output logic                   Game_Over,
    output logic [PW-1:0]          Active_Player,
    output logic [RW-1:0]          Round
);

    localparam logic [RW-1:0] ROUND_SAT   = '1;
    localparam logic [PW-1:0] LAST_PLAYER = PW'(NUM_PLAYERS - 1);
    localparam logic [RW-1:0] ROUND_LIMIT = RW'(MAX_ROUNDS);

    typedef enum logic [2:0] {
        S_INIT     = 3'd0,
        S_SETUP    = 3'd1,
        S_RNGING   = 3'd2,
        S_NEWRNG   = 3'd3,
        S_PTURN    = 3'd4,
        S_VERIFY   = 3'd5,
        S_GAMEOVER = 3'd6,
        S_LOGOUT   = 3'd7
    } state_t;

    state_t                   state;
    state_t                   state_nx;

    logic                     press_hit;
    logic [PW-1:0]            press_idx;
    logic [NUM_PLAYERS-1:0]   press_oh;

    logic [PW-1:0]            ap_adv;
    logic [RW-1:0]            round_adv;
    logic                     round_bump;
    logic                     round_limit;

    logic                     log_out_d;
    logic                     pwd_res_d;
    logic [NUM_PLAYERS-1:0]   p_load_d;
    logic                     rng_load_d;
    logic                     timer_en_d;
    logic                     time_reconfig_d;
    logic                     game_over_d;
    logic [PW-1:0]            active_player_d;
    logic [RW-1:0]            round_d;

    // Press qualification: owner-only in rotate mode, lowest index in free mode
    always_comb begin
        press_hit = 1'b0;
        press_idx = Active_Player;
        press_oh  = '0;
        if (ROTATE != 0) begin
            for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
                if ((Active_Player == PW'(i)) && P_Pls[i]) begin
                    press_hit = 1'b1;
                end
            end
        end else begin
            for (int i = int'(NUM_PLAYERS) - 1; i >= 0; i--) begin
                if (P_Pls[i]) begin
                    press_hit = 1'b1;
                    press_idx = PW'(i);
                end
            end
        end
        for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
            press_oh[i] = (press_idx == PW'(i));
        end
    end

    // Turn/round advance applied in VERIFY; round count saturates instead of wrapping
    always_comb begin
        ap_adv     = Active_Player;
        round_bump = 1'b0;
        if (ROTATE != 0) begin
            if (Active_Player == LAST_PLAYER) begin
                ap_adv     = '0;
                round_bump = 1'b1;
            end else begin
                ap_adv = Active_Player + 1'b1;
            end
        end else begin
            round_bump = 1'b1;
        end
        round_adv = Round;
        if (round_bump && (Round != ROUND_SAT)) begin
            round_adv = Round + 1'b1;
        end
        round_limit = (MAX_ROUNDS != 0) && (round_adv == ROUND_LIMIT);
    end

    // Next-state decode; input priority follows the order of the checks
    always_comb begin
        state_nx = state;
        case (state)
            S_INIT: begin
                if (Log_In) state_nx = S_SETUP;
            end
            S_SETUP: begin
                if (P_Pls[0])     state_nx = S_LOGOUT;
                else if (Log_Pls) state_nx = S_RNGING;
            end
            S_RNGING: begin
                if (Log_Pls)       state_nx = S_SETUP;
                else if (Time_Out) state_nx = S_GAMEOVER;
                else if (!RNG_Pls) state_nx = S_NEWRNG;
            end
            S_NEWRNG: begin
                if (RNG_Pls)       state_nx = S_PTURN;
                else if (Time_Out) state_nx = S_GAMEOVER;
            end
            S_PTURN: begin
                if (Log_Pls)        state_nx = S_SETUP;
                else if (Time_Out)  state_nx = S_GAMEOVER;
                else if (press_hit) state_nx = S_VERIFY;
            end
            S_VERIFY: begin
                state_nx = round_limit ? S_GAMEOVER : S_RNGING;
            end
            S_GAMEOVER: begin
                if (Log_Pls) state_nx = S_SETUP;
            end
            S_LOGOUT: begin
                state_nx = S_INIT;
            end
            default: begin
                state_nx = S_INIT;
            end
        endcase
    end

    // Next output values, derived from the current state and the chosen transition
    always_comb begin
        log_out_d       = Log_Out;
        pwd_res_d       = Pwd_Res;
        rng_load_d      = RNG_Load;
        active_player_d = Active_Player;
        round_d         = Round;
        p_load_d        = '0;
        time_reconfig_d = 1'b0;
        timer_en_d      = (state_nx == S_RNGING) || (state_nx == S_NEWRNG) ||
                          (state_nx == S_PTURN)  || (state_nx == S_VERIFY);
        game_over_d     = (state_nx == S_GAMEOVER);

        // Any fresh entry into SETUP (login, abort, restart) reloads the timer and clears the game
        if ((state_nx == S_SETUP) && (state != S_SETUP)) begin
            time_reconfig_d = 1'b1;
            active_player_d = '0;
            round_d         = '0;
        end

        case (state)
            S_INIT: begin
                rng_load_d = 1'b1;
                log_out_d  = 1'b0;
                pwd_res_d  = 1'b0;
            end
            S_SETUP: begin
                if (state_nx == S_LOGOUT) begin
                    log_out_d = 1'b1;
                    pwd_res_d = !RNG_Pls;
                end
            end
            S_RNGING: begin
                if (state_nx == S_NEWRNG) rng_load_d = 1'b0;
            end
            S_NEWRNG: begin
                if (state_nx == S_PTURN) rng_load_d = 1'b1;
            end
            S_PTURN: begin
                if (state_nx == S_VERIFY) begin
                    p_load_d        = press_oh;
                    active_player_d = press_idx;
                end
            end
            S_VERIFY: begin
                active_player_d = ap_adv;
                round_d         = round_adv;
            end
            default: begin
            end
        endcase
    end

    // State register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= S_INIT;
        end else begin
            state <= state_nx;
        end
    end

    // Output registers
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Log_Out       <= 1'b0;
            Pwd_Res       <= 1'b0;
            P_Load        <= '0;
            RNG_Load      <= 1'b1;
            Timer_En      <= 1'b0;
            Time_Reconfig <= 1'b0;
            Game_Over     <= 1'b0;
            Active_Player <= '0;
            Round         <= '0;
        end else begin
            Log_Out       <= log_out_d;
            Pwd_Res       <= pwd_res_d;
            P_Load        <= p_load_d;
            RNG_Load      <= rng_load_d;
            Timer_En      <= timer_en_d;
            Time_Reconfig <= time_reconfig_d;
            Game_Over     <= game_over_d;
            Active_Player <= active_player_d;
            Round         <= round_d;
        end
    end

endmodule

// File: tb/tb_game_control_mp.sv
// Bench for game_control_mp: a rotate-mode instance (2 players, 2 rounds) and a
// free-mode instance (4 players, unlimited rounds, 3-bit round count) share stimulus.
module tb_game_control_mp;

    localparam int PH_INIT  = 0;
    localparam int PH_SETUP = 1;
    localparam int PH_RNG   = 2;
    localparam int PH_NEW   = 3;
    localparam int PH_TURN  = 4;
    localparam int PH_VER   = 5;
    localparam int PH_OVER  = 6;
    localparam int PH_OUT   = 7;

    typedef struct {
        int ph;
        int lo, pr, pl, rl, te, tr, go, ap, rnd;
    } mdl_t;

    typedef struct {
        logic        li, lp;
        logic [3:0]  pp;
        logic        rp, to;
        logic [31:0] exp;
    } vec_t;

    logic       Clk = 1'b0;
    logic       Rst, Log_In, Log_Pls, RNG_Pls, Time_Out;
    logic [3:0] P_Pls;

    logic       a_log_out, a_pwd_res, a_rng_load, a_timer_en, a_time_reconfig, a_game_over;
    logic [1:0] a_p_load;
    logic [2:0] a_active_player;
    logic [3:0] a_round;

    logic       b_log_out, b_pwd_res, b_rng_load, b_timer_en, b_time_reconfig, b_game_over;
    logic [3:0] b_p_load;
    logic [1:0] b_active_player;
    logic [2:0] b_round;

    int   nerr = 0;
    int   nchk = 0;
    mdl_t ma, mb;
    vec_t tbl[$];

    game_control_mp #(.NUM_PLAYERS(2), .ROTATE(1), .MAX_ROUNDS(2), .PW(3), .RW(4)) dut_a (
        .Clk(Clk), .Rst(Rst), .Log_In(Log_In), .Log_Pls(Log_Pls), .P_Pls(P_Pls[1:0]),
        .RNG_Pls(RNG_Pls), .Time_Out(Time_Out), .Log_Out(a_log_out), .Pwd_Res(a_pwd_res),
        .P_Load(a_p_load), .RNG_Load(a_rng_load), .Timer_En(a_timer_en),
        .Time_Reconfig(a_time_reconfig), .Game_Over(a_game_over),
        .Active_Player(a_active_player), .Round(a_round)
    );

    game_control_mp #(.NUM_PLAYERS(4), .ROTATE(0), .MAX_ROUNDS(0), .PW(2), .RW(3)) dut_b (
        .Clk(Clk), .Rst(Rst), .Log_In(Log_In), .Log_Pls(Log_Pls), .P_Pls(P_Pls),
        .RNG_Pls(RNG_Pls), .Time_Out(Time_Out), .Log_Out(b_log_out), .Pwd_Res(b_pwd_res),
        .P_Load(b_p_load), .RNG_Load(b_rng_load), .Timer_En(b_timer_en),
        .Time_Reconfig(b_time_reconfig), .Game_Over(b_game_over),
        .Active_Player(b_active_player), .Round(b_round)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] pack_a(int lo, int pr, int pl, int rl, int te, int tr,
                                           int go, int ap, int rnd);
        return 32'({1'(lo), 1'(pr), 2'(pl), 1'(rl), 1'(te), 1'(tr), 1'(go), 3'(ap), 4'(rnd)});
    endfunction

    function automatic logic [31:0] pack_b(int lo, int pr, int pl, int rl, int te, int tr,
                                           int go, int ap, int rnd);
        return 32'({1'(lo), 1'(pr), 4'(pl), 1'(rl), 1'(te), 1'(tr), 1'(go), 2'(ap), 3'(rnd)});
    endfunction

    function automatic logic [31:0] act_a();
        return 32'({a_log_out, a_pwd_res, a_p_load, a_rng_load, a_timer_en, a_time_reconfig,
                    a_game_over, a_active_player, a_round});
    endfunction

    function automatic logic [31:0] act_b();
        return 32'({b_log_out, b_pwd_res, b_p_load, b_rng_load, b_timer_en, b_time_reconfig,
                    b_game_over, b_active_player, b_round});
    endfunction

    function automatic mdl_t mreset();
        mdl_t r;
        r.ph = PH_INIT; r.lo = 0; r.pr = 0; r.pl = 0; r.rl = 1;
        r.te = 0; r.tr = 0; r.go = 0; r.ap = 0; r.rnd = 0;
        return r;
    endfunction

    function automatic mdl_t to_setup(input mdl_t m);
        mdl_t r = m;
        r.tr = 1; r.te = 0; r.go = 0; r.rnd = 0; r.ap = 0; r.ph = PH_SETUP;
        return r;
    endfunction

    function automatic mdl_t to_over(input mdl_t m);
        mdl_t r = m;
        r.go = 1; r.te = 0; r.ph = PH_OVER;
        return r;
    endfunction

    // Game rules as a transition over game phases, producing next-cycle outputs
    function automatic mdl_t mstep(input mdl_t m, input int n, input bit rot, input int maxr,
                                   input int rw, input logic li, input logic lp,
                                   input logic [3:0] pp, input logic rp, input logic to);
        mdl_t r;
        int   win;
        r = m; r.tr = 0; r.pl = 0;
        case (m.ph)
            PH_INIT: begin
                r.rl = 1; r.lo = 0; r.pr = 0;
                if (li) begin r.tr = 1; r.rnd = 0; r.ap = 0; r.ph = PH_SETUP; end
            end
            PH_SETUP: begin
                if (pp[0]) begin r.lo = 1; r.pr = rp ? 0 : 1; r.ph = PH_OUT; end
                else if (lp) begin r.te = 1; r.ph = PH_RNG; end
            end
            PH_RNG: begin
                if (lp) r = to_setup(r);
                else if (to) r = to_over(r);
                else if (!rp) begin r.rl = 0; r.ph = PH_NEW; end
            end
            PH_NEW: begin
                if (rp) begin r.rl = 1; r.ph = PH_TURN; end
                else if (to) r = to_over(r);
            end
            PH_TURN: begin
                if (lp) r = to_setup(r);
                else if (to) r = to_over(r);
                else begin
                    win = -1;
                    if (rot) begin
                        if (pp[m.ap]) win = m.ap;
                    end else begin
                        for (int i = n - 1; i >= 0; i--) if (pp[i]) win = i;
                    end
                    if (win >= 0) begin r.pl = 1 << win; r.ap = win; r.ph = PH_VER; end
                end
            end
            PH_VER: begin
                if (!rot || m.ap == n - 1) r.rnd = m.rnd + 1;
                if (rot) r.ap = (m.ap == n - 1) ? 0 : m.ap + 1;
                if (r.rnd > (1 << rw) - 1) r.rnd = (1 << rw) - 1;
                if (maxr != 0 && r.rnd == maxr) r = to_over(r);
                else r.ph = PH_RNG;
            end
            PH_OVER: begin
                if (lp) r = to_setup(r);
            end
            default: r.ph = PH_INIT;
        endcase
        return r;
    endfunction

    function automatic vec_t mk(input logic li, input logic lp, input logic [3:0] pp,
                                input logic rp, input logic to, input int lo, input int pr,
                                input int pl, input int rl, input int te, input int tr,
                                input int go, input int ap, input int rnd);
        vec_t v;
        v.li = li; v.lp = lp; v.pp = pp; v.rp = rp; v.to = to;
        v.exp = pack_a(lo, pr, pl, rl, te, tr, go, ap, rnd);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic li, input logic lp, input logic [3:0] pp,
                         input logic rp, input logic to);
        Log_In = li; Log_Pls = lp; P_Pls = pp; RNG_Pls = rp; Time_Out = to;
    endtask

    // One clock: sample after the edge, advance both models, compare both instances
    task automatic tick();
        @(posedge Clk);
        #1;
        if (Rst) begin
            ma = mreset();
            mb = mreset();
        end else begin
            ma = mstep(ma, 2, 1'b1, 2, 4, Log_In, Log_Pls, {2'b00, P_Pls[1:0]}, RNG_Pls, Time_Out);
            mb = mstep(mb, 4, 1'b0, 0, 3, Log_In, Log_Pls, P_Pls, RNG_Pls, Time_Out);
        end
        check("model_a", act_a(), pack_a(ma.lo, ma.pr, ma.pl, ma.rl, ma.te, ma.tr, ma.go, ma.ap, ma.rnd));
        check("model_b", act_b(), pack_b(mb.lo, mb.pr, mb.pl, mb.rl, mb.te, mb.tr, mb.go, mb.ap, mb.rnd));
    endtask

    initial begin
        // inputs: li lp pp rp to | expected: lo pr pl rl te tr go ap rnd
        tbl.push_back(mk(1, 0, 4'h0, 1, 0,  0, 0, 0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4'h0, 1, 0,  0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4'h0, 1, 0,  0, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4'h0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4'h0, 1, 0,  0, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4'h2, 1, 0,  0, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4'h1, 1, 0,  0, 0, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4'h0, 1, 0,  0, 0, 0, 1, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 4'h0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 4'h0, 1, 0,  0, 0, 0, 1, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 4'h2, 1, 0,  0, 0, 2, 1, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 4'h0, 1, 0,  0, 0, 0, 1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 4'h0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 4'h0, 1, 0,  0, 0, 0, 1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 4'h3, 1, 0,  0, 0, 1, 1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 4'h0, 1, 0,  0, 0, 0, 1, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 4'h0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 4'h0, 1, 0,  0, 0, 0, 1, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 4'h2, 1, 0,  0, 0, 2, 1, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 4'h0, 1, 0,  0, 0, 0, 1, 0, 0, 1, 0, 2));
        tbl.push_back(mk(0, 0, 4'h0, 1, 0,  0, 0, 0, 1, 0, 0, 1, 0, 2));
        tbl.push_back(mk(0, 1, 4'h0, 1, 0,  0, 0, 0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4'h0, 1, 0,  0, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4'h0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4'h0, 1, 0,  0, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4'h1, 1, 0,  0, 0, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4'h0, 1, 0,  0, 0, 0, 1, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 4'h0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 4'h0, 1, 0,  0, 0, 0, 1, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 4'h2, 1, 0,  0, 0, 2, 1, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 4'h0, 1, 0,  0, 0, 0, 1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 4'h0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 4'h0, 1, 0,  0, 0, 0, 1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 4'h0, 1, 0,  0, 0, 0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4'h0, 1, 0,  0, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4'h0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4'h0, 1, 0,  0, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4'h1, 1, 1,  0, 0, 0, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 4'h0, 1, 0,  0, 0, 0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4'h1, 0, 0,  1, 1, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4'h0, 1, 0,  1, 1, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4'h0, 1, 0,  0, 0, 0, 1, 0, 0, 0, 0, 0));

        // Reset state
        Rst = 1'b1;
        drive(0, 0, 4'h0, 1, 0);
        ma = mreset();
        mb = mreset();
        tick();
        tick();
        check("reset_a", act_a(), pack_a(0, 0, 0, 1, 0, 0, 0, 0, 0));
        check("reset_b", act_b(), pack_b(0, 0, 0, 1, 0, 0, 0, 0, 0));
        Rst = 1'b0;

        // Rotate-mode game, abort, timeout race and logout on instance A
        foreach (tbl[i]) begin
            drive(tbl[i].li, tbl[i].lp, tbl[i].pp, tbl[i].rp, tbl[i].to);
            tick();
            check($sformatf("vec%0d", i), act_a(), tbl[i].exp);
        end

        // Free mode: lowest pressed index wins
        Rst = 1'b1;
        drive(0, 0, 4'h0, 1, 0);
        tick();
        Rst = 1'b0;
        drive(1, 0, 4'h0, 1, 0); tick();
        drive(0, 1, 4'h0, 1, 0); tick();
        drive(0, 0, 4'h0, 0, 0); tick();
        drive(0, 0, 4'h0, 1, 0); tick();
        drive(0, 0, 4'b1010, 1, 0); tick();
        check("free_pload", 32'(b_p_load), 32'h2);
        check("free_ap", 32'(b_active_player), 32'd1);
        drive(0, 0, 4'h0, 1, 0); tick();
        check("free_round1", 32'(b_round), 32'd1);
        check("free_pload_clr", 32'(b_p_load), 32'd0);

        // Unlimited rounds: count saturates at 7 without ending the game
        for (int r = 0; r < 8; r++) begin
            drive(0, 0, 4'h0, 0, 0); tick();
            drive(0, 0, 4'h0, 1, 0); tick();
            drive(0, 0, 4'b1000, 1, 0); tick();
            drive(0, 0, 4'h0, 1, 0); tick();
        end
        check("sat_round", 32'(b_round), 32'd7);
        check("sat_ap", 32'(b_active_player), 32'd3);
        check("sat_no_gameover", 32'(b_game_over), 32'd0);

        // Time_Out together with a press: the press is dropped
        drive(0, 0, 4'h0, 0, 0); tick();
        drive(0, 0, 4'h0, 1, 0); tick();
        drive(0, 0, 4'b0100, 1, 1); tick();
        check("race_gameover", 32'(b_game_over), 32'd1);
        check("race_pload", 32'(b_p_load), 32'd0);
        drive(0, 0, 4'h0, 1, 0); tick();
        check("race_pload_after", 32'(b_p_load), 32'd0);

        // Asynchronous reset in RNGING takes effect before the next edge
        drive(0, 1, 4'h0, 1, 0); tick();
        drive(0, 1, 4'h0, 1, 0); tick();
        check("pre_rst_timer", 32'(b_timer_en), 32'd1);
        drive(0, 0, 4'h0, 1, 0);
        Rst = 1'b1;
        #2;
        check("async_a", act_a(), pack_a(0, 0, 0, 1, 0, 0, 0, 0, 0));
        check("async_b", act_b(), pack_b(0, 0, 0, 1, 0, 0, 0, 0, 0));
        tick();
        Rst = 1'b0;

        // Randomized traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            Rst      = ($urandom_range(0, 399) == 0);
            Log_In   = ($urandom_range(0, 3) == 0);
            Log_Pls  = ($urandom_range(0, 9) == 0);
            P_Pls    = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 2) == 0) RNG_Pls = ~RNG_Pls;
            Time_Out = ($urandom_range(0, 24) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/game_control_mp.md
Name: game_control_mp

Overview:
Multi-player successor of the single-player game-control FSM. It sequences login, setup, RNG capture, player turns, verification, game-over and logout for NUM_PLAYERS players. Turns are either rotating or first-press, and the game ends on a round limit or on timeout. It sits between the button debouncers/pulse generators, the RNG, the game timer and the per-player entry registers.

Parameters:
NUM_PLAYERS, 2, number of players (1..8)
ROTATE, 1, 1 = strict turn rotation; 0 = free mode, any player may answer
MAX_ROUNDS, 4, completed rounds before GAMEOVER; 0 = unlimited
PW, 3, width of Active_Player; must satisfy 2^PW >= NUM_PLAYERS
RW, 4, width of Round; must satisfy 2^RW > MAX_ROUNDS

Ports:
Clk  in  1  system clock, rising edge
Rst  in  1  asynchronous reset, active-high
Log_In  in  1  login accepted (level)
Log_Pls  in  1  one-cycle log/start/abort pulse
P_Pls  in  NUM_PLAYERS  one-cycle button pulse per player
RNG_Pls  in  1  RNG button level (active-low request)
Time_Out  in  1  game timer expired (level)
Log_Out  out  1  logout request
Pwd_Res  out  1  password reset request
P_Load  out  NUM_PLAYERS  one-hot load strobe to player entry registers
RNG_Load  out  1  RNG register load enable (1 = free-running load, 0 = hold)
Timer_En  out  1  game timer enable
Time_Reconfig  out  1  one-cycle timer reload pulse
Game_Over  out  1  high while in GAMEOVER
Active_Player  out  PW  index of the player whose turn it is; in free mode, the last answering player
Round  out  RW  completed-round count

Behaviour:
- All outputs are registered. Each output changes on the clock edge after the causing input.
- Reset (async, Rst=1) forces State=INIT, RNG_Load=1, Active_Player=0 and Round=0. Every other output is 0.
- INIT:
  - Drives RNG_Load=1. All other control outputs are 0.
  - Log_In=1 -> pulse Time_Reconfig for one cycle; clear Round and Active_Player; go to SETUP.
- SETUP:
  - Drives P_Load=0, Timer_En=0, Time_Reconfig=0 (except a pulse issued on entry).
  - P_Pls[0]=1 -> Log_Out=1; also Pwd_Res=1 if RNG_Pls=0; go to LOGOUT.
  - Otherwise Log_Pls=1 -> Timer_En=1; go to RNGING.
  - P_Pls[0] has priority over Log_Pls.
- RNGING, priority order:
  - Log_Pls -> abort: pulse Time_Reconfig, Timer_En=0, clear Round and Active_Player, go to SETUP.
  - Time_Out -> GAMEOVER.
  - RNG_Pls=0 -> RNG_Load=0, go to NEWRNG.
- NEWRNG, priority order:
  - RNG_Pls=1 -> RNG_Load=1, go to PTURN.
  - Time_Out -> GAMEOVER.
- PTURN, priority order:
  - Log_Pls -> abort (same as RNGING).
  - Time_Out -> GAMEOVER.
  - Valid press -> P_Load = one-hot of the answering player for exactly one cycle; go to VERIFY.
  - A valid press is:
    - ROTATE=1: only P_Pls[Active_Player] counts; other bits are ignored.
    - ROTATE=0: any bit counts; the lowest set index wins, and Active_Player is loaded with that index.
- VERIFY (one cycle):
  - P_Load=0.
  - ROTATE=1: if Active_Player==NUM_PLAYERS-1, set Active_Player=0 and Round=Round+1; otherwise Active_Player+1.
  - ROTATE=0: Round+1 on every verify.
  - If MAX_ROUNDS!=0 and the new Round==MAX_ROUNDS -> GAMEOVER; otherwise go to RNGING.
  - With MAX_ROUNDS=0, Round saturates at 2^RW-1 (no wrap).
- GAMEOVER:
  - Game_Over=1, P_Load=0, Timer_En=0.
  - Log_Pls -> pulse Time_Reconfig, clear Round and Active_Player, Game_Over=0, go to SETUP.
- LOGOUT: one cycle, then go to INIT; INIT clears Log_Out and Pwd_Res.
- Illegal state encodings go to INIT.
- P_Load is never more than one-hot and is never asserted outside the cycle that follows a PTURN acceptance.
- Time_Out arriving in the same cycle as a valid press: Time_Out wins and the press is dropped.
- Rst asserted mid-game: immediate return to reset values, with no pulses emitted.

Test Plan:
- Reset, then Log_In=1 -> Time_Reconfig high for exactly 1 cycle, state SETUP, RNG_Load=1, Round=0.
- SETUP with P_Pls=2'b01 and RNG_Pls=0 -> Log_Out=1, Pwd_Res=1 next cycle; INIT two cycles later with both cleared.
- NUM_PLAYERS=2, ROTATE=1, MAX_ROUNDS=2: Log_Pls, then 4 turns (RNG_Pls 1->0->1 each, correct player presses) -> P_Load sequence 01,10,01,10; Round goes 0,1,1,2; Game_Over=1 after the 4th VERIFY.
- ROTATE=1, Active_Player=0, P_Pls=2'b10 in PTURN -> no P_Load, state stays PTURN; then P_Pls=2'b01 -> P_Load=2'b01 for 1 cycle.
- ROTATE=0, NUM_PLAYERS=4, P_Pls=4'b1010 -> P_Load=4'b0010 and Active_Player=1. In a separate run, Time_Out=1 with P_Pls in the same cycle -> GAMEOVER, P_Load stays 0.
- Log_Pls in PTURN with Round=1 -> Time_Reconfig pulse, Timer_En=0, Round=0, state SETUP. Then Rst asserted asynchronously mid-RNGING -> outputs at reset values before the next Clk edge.
